// File: rtl/scroll_msg_display.sv
// Multiplexed common-anode 7-segment driver showing a scrollable window of a
// loadable message buffer; all outputs are registered.
module scroll_msg_display #(
  parameter int N_DIGITS    = 8,
  parameter int MSG_LEN     = 16,
  parameter int REFRESH_DIV = 100000,
  parameter int SCROLL_DIV  = 25000000
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [MSG_LEN*7-1:0]                              msg_seg,
  input  logic                                              load,
  input  logic                                              scroll_en,
  input  logic                                              scroll_dir,
  output logic [N_DIGITS-1:0]                               AN,
  output logic [6:0]                                        D7S,
  output logic [((MSG_LEN > 1) ? $clog2(MSG_LEN) : 1)-1:0]  offset,
  output logic                                              wrap
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int OW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int IW = OW + 1;

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCROLL_LAST  = SW'(SCROLL_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST   = DW'(N_DIGITS - 1);
  localparam logic [OW-1:0] OFFSET_LAST  = OW'(MSG_LEN - 1);
  localparam logic [6:0]    SEG_BLANK    = 7'h7F;

  logic [RW-1:0]               refresh_cnt_q, refresh_cnt_d;
  logic [SW-1:0]               scroll_cnt_q,  scroll_cnt_d;
  logic [DW-1:0]               digit_q,       digit_d;
  logic [OW-1:0]               offset_q,      offset_d;
  logic                        wrap_q,        wrap_d;
  logic [MSG_LEN-1:0][6:0]     buf_q,         buf_d;
  logic [N_DIGITS-1:0]         an_q,          an_d;
  logic [6:0]                  d7s_q,         d7s_d;

  logic                        refresh_tick_s;
  logic                        scroll_tick_s;
  logic [IW-1:0]               idx_sum_s;
  logic [OW-1:0]               char_idx_s;

  // Digit-scan divider and digit index.
  always_comb begin
    refresh_tick_s = (refresh_cnt_q == REFRESH_LAST);
    refresh_cnt_d  = refresh_cnt_q;
    digit_d        = digit_q;
    if (refresh_tick_s) begin
      refresh_cnt_d = '0;
      if (digit_q == DIGIT_LAST) begin
        digit_d = '0;
      end else begin
        digit_d = digit_q + DW'(1);
      end
    end else begin
      refresh_cnt_d = refresh_cnt_q + RW'(1);
    end
  end

  // Scroll divider, window offset, wrap pulse and buffer load; load beats a tick.
  always_comb begin
    scroll_tick_s = scroll_en && (scroll_cnt_q == SCROLL_LAST);
    scroll_cnt_d  = scroll_cnt_q;
    offset_d      = offset_q;
    wrap_d        = 1'b0;
    buf_d         = buf_q;
    if (load) begin
      buf_d        = msg_seg;
      offset_d     = '0;
      scroll_cnt_d = '0;
    end else if (scroll_tick_s) begin
      scroll_cnt_d = '0;
      if (!scroll_dir) begin
        if (offset_q == OFFSET_LAST) begin
          offset_d = '0;
          wrap_d   = 1'b1;
        end else begin
          offset_d = offset_q + OW'(1);
        end
      end else begin
        if (offset_q == '0) begin
          offset_d = OFFSET_LAST;
          wrap_d   = 1'b1;
        end else begin
          offset_d = offset_q - OW'(1);
        end
      end
    end else if (scroll_en) begin
      scroll_cnt_d = scroll_cnt_q + SW'(1);
    end else begin
      scroll_cnt_d = scroll_cnt_q;
    end
  end

  // Character for the current digit: (offset + N_DIGITS-1-digit) mod MSG_LEN.
  always_comb begin
    idx_sum_s = IW'(offset_q) + (IW'(N_DIGITS - 1) - IW'(digit_q));
    if (idx_sum_s >= IW'(MSG_LEN)) begin
      char_idx_s = OW'(idx_sum_s - IW'(MSG_LEN));
    end else begin
      char_idx_s = OW'(idx_sum_s);
    end
  end

  // Next digit enables and segment pattern.
  always_comb begin
    an_d = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      an_d[i] = (digit_q != DW'(i));
    end
    d7s_d = buf_q[char_idx_s];
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt_q <= '0;
      scroll_cnt_q  <= '0;
      digit_q       <= '0;
      offset_q      <= '0;
      wrap_q        <= 1'b0;
      buf_q         <= {MSG_LEN{SEG_BLANK}};
      an_q          <= '1;
      d7s_q         <= SEG_BLANK;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      scroll_cnt_q  <= scroll_cnt_d;
      digit_q       <= digit_d;
      offset_q      <= offset_d;
      wrap_q        <= wrap_d;
      buf_q         <= buf_d;
      an_q          <= an_d;
      d7s_q         <= d7s_d;
    end
  end

  assign AN     = an_q;
  assign D7S    = d7s_q;
  assign offset = offset_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_scroll_msg_display.sv
// Directed bench for scroll_msg_display with N_DIGITS=4, MSG_LEN=6,
// REFRESH_DIV=4, SCROLL_DIV=10; characters 0..5 are patterns 7'h01..7'h06.
module tb_scroll_msg_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [41:0] msg_seg;
  logic [41:0] msg_ref;
  logic        load;
  logic        scroll_en;
  logic        scroll_dir;
  logic [3:0]  AN;
  logic [6:0]  D7S;
  logic [2:0]  offset;
  logic        wrap;

  int n_checks = 0;
  int n_fail   = 0;
  int wrap_hi  = 0;

  scroll_msg_display #(
    .N_DIGITS(4), .MSG_LEN(6), .REFRESH_DIV(4), .SCROLL_DIV(10)
  ) dut (
    .clk(clk), .reset(reset), .msg_seg(msg_seg), .load(load),
    .scroll_en(scroll_en), .scroll_dir(scroll_dir),
    .AN(AN), .D7S(D7S), .offset(offset), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock, then sample 1 ns after the edge; wrap-high cycles are tallied.
  task automatic step();
    @(posedge clk);
    #1;
    if (wrap === 1'b1) wrap_hi++;
  endtask

  task automatic wait_change(input int max, output int n);
    logic [2:0] prev;
    prev = offset;
    n = 0;
    do begin
      step();
      n++;
    end while (offset == prev && n < max);
    if (offset == prev) check_eq("step_timeout", 32'(n), 32'(max + 1));
  endtask

  function automatic logic [3:0] an_for(input int d);
    logic [3:0] e;
    e = 4'b1111;
    e[d] = 1'b0;
    return e;
  endfunction

  function automatic int digit_of(input logic [3:0] an);
    int d;
    d = -1;
    for (int i = 0; i < 4; i++) begin
      if (an == an_for(i)) d = i;
    end
    return d;
  endfunction

  initial begin
    int n;
    int d;
    logic [6:0] exp4 [4];
    logic found;

    // At offset 4: digit0..3 show chars 1,0,5,4.
    exp4[0] = 7'h02; exp4[1] = 7'h01; exp4[2] = 7'h06; exp4[3] = 7'h05;
    for (int i = 0; i < 6; i++) msg_ref[7*i +: 7] = 7'(i + 1);

    reset = 1'b1; load = 1'b0; scroll_en = 1'b0; scroll_dir = 1'b0;
    msg_seg = msg_ref;
    step(); step();
    check_eq("rst_an", 32'(AN), 32'h0F);
    check_eq("rst_d7s", 32'(D7S), 32'h7F);
    check_eq("rst_offset", 32'(offset), 32'd0);
    check_eq("rst_wrap", 32'(wrap), 32'd0);

    // Scan after load: each digit held 4 clk; first update still shows the blank buffer.
    reset = 1'b0; load = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      load = 1'b0;
      d = ((k - 1) / 4) % 4;
      check_eq("scan_an", 32'(AN), 32'(an_for(d)));
      check_eq("scan_d7s", 32'(D7S), (k == 1) ? 32'h7F : 32'(4 - d));
    end

    // Left scroll through a full wrap, freezing at offset 4 to inspect all digits.
    wrap_hi = 0;
    scroll_en = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      wait_change(20, n);
      check_eq("left_period", 32'(n), 32'd10);
      check_eq("left_offset", 32'(offset), 32'(s % 6));
      check_eq("left_wrap", 32'(wrap), (s == 6) ? 32'd1 : 32'd0);
      if (s == 4) begin
        scroll_en = 1'b0;
        msg_seg = '0;
        for (int k = 0; k < 16; k++) begin
          step();
          d = digit_of(AN);
          check_eq("onehot_an", (d >= 0) ? 32'd1 : 32'd0, 32'd1);
          if (d >= 0) check_eq("off4_d7s", 32'(D7S), 32'(exp4[d]));
        end
        check_eq("frozen_offset", 32'(offset), 32'd4);
        msg_seg = msg_ref;
        scroll_en = 1'b1;
      end
    end
    scroll_dir = 1'b1;
    step();
    check_eq("wrap_one_cycle", 32'(wrap), 32'd0);
    check_eq("wrap_count", 32'(wrap_hi), 32'd1);

    // Right scroll from 0; one clk of the period was spent above.
    wait_change(20, n);
    check_eq("right_period1", 32'(n), 32'd9);
    check_eq("right_offset1", 32'(offset), 32'd5);
    check_eq("right_wrap1", 32'(wrap), 32'd1);
    wait_change(20, n);
    check_eq("right_period2", 32'(n), 32'd10);
    check_eq("right_offset2", 32'(offset), 32'd4);
    check_eq("right_wrap2", 32'(wrap), 32'd0);

    // Pause with the scroll count held at 7; three enabled clk finish the period.
    repeat (7) step();
    scroll_en = 1'b0;
    repeat (50) step();
    check_eq("pause_offset", 32'(offset), 32'd4);
    scroll_en = 1'b1;
    wait_change(20, n);
    check_eq("resume_latency", 32'(n), 32'd3);
    check_eq("resume_offset", 32'(offset), 32'd3);

    // Load lands on the same edge as a scroll tick.
    repeat (9) step();
    check_eq("pre_load_offset", 32'(offset), 32'd3);
    load = 1'b1;
    step();
    load = 1'b0;
    check_eq("load_offset", 32'(offset), 32'd0);
    check_eq("load_wrap", 32'(wrap), 32'd0);
    wait_change(20, n);
    check_eq("post_load_period", 32'(n), 32'd10);
    check_eq("post_load_offset", 32'(offset), 32'd5);

    // Reach offset 4, then reset while digit 2 is displayed.
    wait_change(20, n);
    check_eq("pre_rst_offset", 32'(offset), 32'd4);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (AN == 4'b1011) found = 1'b1;
    end
    check_eq("digit2_found", 32'(found), 32'd1);
    scroll_en = 1'b0;
    reset = 1'b1;
    step();
    check_eq("mid_rst_an", 32'(AN), 32'h0F);
    check_eq("mid_rst_d7s", 32'(D7S), 32'h7F);
    check_eq("mid_rst_offset", 32'(offset), 32'd0);
    check_eq("mid_rst_wrap", 32'(wrap), 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      d = ((k - 1) / 4) % 4;
      check_eq("rescan_an", 32'(AN), 32'(an_for(d)));
      check_eq("rescan_d7s", 32'(D7S), 32'h7F);
    end
    check_eq("rescan_offset", 32'(offset), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
